// File: rtl/rpm_pkg.sv
// Shared types and helpers for the rpm_window_monitor tachometer.
package rpm_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } win_state_e;

  localparam int DEF_N_CH          = 2;
  localparam int DEF_CNT_W         = 8;
  localparam int DEF_WINDOW_CYCLES = 100000;
  localparam int DEF_BUZZ_HALF     = 5000;
  localparam int DEF_DEGLITCH_CYC  = 4;

  // Working width of the saturating helper; callers cast in and out.
  localparam int SAT_W = 32;

  // Add one when inc is set, never passing max_v.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] a,
                                               input logic             inc,
                                               input logic [SAT_W-1:0] max_v);
    if (inc && (a < max_v)) begin
      return a + SAT_W'(1);
    end
    return a;
  endfunction

endpackage

// File: rtl/rpm_channel.sv
// One tachometer channel: synchroniser, optional level deglitch, rising-edge
// strobe, saturating window counter, published count and hysteresis alarm.
// With RPM_DEGLITCH_EN defined a level change is accepted only after
// DEGLITCH_CYC consecutive agreeing samples.
module rpm_channel
  import rpm_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
`ifdef RPM_DEGLITCH_EN
  , parameter int DEGLITCH_CYC = DEF_DEGLITCH_CYC
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  input  logic             run,
  input  logic             close,
  input  logic [CNT_W-1:0] thr_hi,
  input  logic [CNT_W-1:0] thr_lo,
  output logic [CNT_W-1:0] count_out,
  output logic             alarm,
  output logic             alarm_nxt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             lvl;
  logic             lvl_prev_q, lvl_prev_d;
  logic             edge_q, edge_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] new_cnt;
  logic [CNT_W-1:0] eff_lo;
  logic             alarm_q, alarm_d;

  // Synchroniser and edge strobe next-state.
  always_comb begin
    sync1_d    = pulse_in;
    sync2_d    = sync1_q;
    lvl_prev_d = lvl;
    edge_d     = lvl & ~lvl_prev_q;
  end

`ifdef RPM_DEGLITCH_EN
  localparam int DG_W = $clog2(DEGLITCH_CYC);

  logic            filt_q, filt_d;
  logic [DG_W-1:0] stab_q, stab_d;

  // Count consecutive samples disagreeing with the filtered level; flip on the last one.
  always_comb begin
    filt_d = filt_q;
    stab_d = '0;
    if (sync2_q != filt_q) begin
      if (stab_q == DG_W'(DEGLITCH_CYC - 1)) begin
        filt_d = sync2_q;
      end else begin
        stab_d = stab_q + DG_W'(1);
      end
    end
  end

  // Deglitch state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      stab_q <= '0;
    end else begin
      filt_q <= filt_d;
      stab_q <= stab_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  // Window counting, publish on close, hysteresis alarm against the new count.
  always_comb begin
    new_cnt = CNT_W'(sat_inc(SAT_W'(cnt_q), edge_q, SAT_W'(CNT_MAX)));
    eff_lo  = (thr_lo < thr_hi) ? thr_lo : thr_hi;
    cnt_d   = '0;
    count_d = count_q;
    alarm_d = alarm_q;
    if (run) begin
      if (close) begin
        count_d = new_cnt;
        if (new_cnt >= thr_hi) begin
          alarm_d = 1'b1;
        end else if (new_cnt < eff_lo) begin
          alarm_d = 1'b0;
        end
      end else begin
        cnt_d = new_cnt;
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      lvl_prev_q <= 1'b0;
      edge_q     <= 1'b0;
      cnt_q      <= '0;
      count_q    <= '0;
      alarm_q    <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      lvl_prev_q <= lvl_prev_d;
      edge_q     <= edge_d;
      cnt_q      <= cnt_d;
      count_q    <= count_d;
      alarm_q    <= alarm_d;
    end
  end

  assign count_out = count_q;
  assign alarm     = alarm_q;
  assign alarm_nxt = alarm_d;

endmodule

// File: rtl/rpm_window_monitor.sv
// Multi-channel gate-window tachometer with per-channel over-speed alarms,
// LED and buzzer. Optional input deglitch enabled by defining RPM_DEGLITCH_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | not gating; window and channel counters held at zero
// ST_COUNT | gating; win_q runs 0..WINDOW_CYCLES-1, counts published at end
module rpm_window_monitor
  import rpm_pkg::*;
#(
  parameter int N_CH          = DEF_N_CH,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int BUZZ_HALF     = DEF_BUZZ_HALF
`ifdef RPM_DEGLITCH_EN
  , parameter int DEGLITCH_CYC = DEF_DEGLITCH_CYC
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [N_CH-1:0]       pulse_in,
  input  logic [CNT_W-1:0]      thr_hi,
  input  logic [CNT_W-1:0]      thr_lo,
  output logic [N_CH*CNT_W-1:0] count_out,
  output logic                  done,
  output logic                  tick,
  output logic [N_CH-1:0]       alarm,
  output logic                  led,
  output logic                  buzzer
);

  localparam int               WIN_W    = $clog2(WINDOW_CYCLES);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam int               BZ_W     = (BUZZ_HALF > 1) ? $clog2(BUZZ_HALF) : 1;
  localparam logic [BZ_W-1:0]  BZ_LOAD  = BZ_W'(BUZZ_HALF - 1);

  win_state_e      state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic            done_q, done_d;
  logic            led_q, led_d;
  logic            buzz_q, buzz_d;
  logic [BZ_W-1:0] bz_cnt_q, bz_cnt_d;
  logic            run;
  logic            close;
  logic [N_CH-1:0] alarm_nxt;

  assign run   = (state_q == ST_COUNT) && en;
  assign close = run && (win_q == WIN_LAST);

  // Window FSM: advance the gate counter, wrap and flag done at the terminal cycle.
  always_comb begin
    state_d = state_q;
    win_d   = '0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (close) begin
          done_d = 1'b1;
        end else begin
          win_d = win_q + WIN_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // LED follows the alarms it summarises; buzzer half-period is a reloading down-counter.
  always_comb begin
    led_d    = |alarm_nxt;
    buzz_d   = buzz_q;
    bz_cnt_d = bz_cnt_q;
    if (!led_d) begin
      buzz_d   = 1'b0;
      bz_cnt_d = '0;
    end else if (!led_q) begin
      buzz_d   = 1'b1;
      bz_cnt_d = BZ_LOAD;
    end else if (bz_cnt_q == '0) begin
      buzz_d   = ~buzz_q;
      bz_cnt_d = BZ_LOAD;
    end else begin
      bz_cnt_d = bz_cnt_q - BZ_W'(1);
    end
  end

  // Top-level state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      win_q    <= '0;
      done_q   <= 1'b0;
      led_q    <= 1'b0;
      buzz_q   <= 1'b0;
      bz_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      done_q   <= done_d;
      led_q    <= led_d;
      buzz_q   <= buzz_d;
      bz_cnt_q <= bz_cnt_d;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    rpm_channel #(
      .CNT_W(CNT_W)
`ifdef RPM_DEGLITCH_EN
      , .DEGLITCH_CYC(DEGLITCH_CYC)
`endif
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .pulse_in  (pulse_in[k]),
      .run       (run),
      .close     (close),
      .thr_hi    (thr_hi),
      .thr_lo    (thr_lo),
      .count_out (count_out[k*CNT_W +: CNT_W]),
      .alarm     (alarm[k]),
      .alarm_nxt (alarm_nxt[k])
    );
  end

  assign tick   = (state_q == ST_COUNT) && (win_q == '0);
  assign done   = done_q;
  assign led    = led_q;
  assign buzzer = buzz_q;

endmodule

// File: tb/tb_rpm_window_monitor.sv
// Directed bench for rpm_window_monitor: a window-by-window vector table plus
// hand sequences for window boundaries, enable drop, reset and short pulses.
module tb_rpm_window_monitor;

`ifdef RPM_DEGLITCH_EN
  localparam int W       = 400;
  localparam int LAT     = 7;
  localparam int PW      = 6;
  localparam int P_SHORT = 2;
  localparam int P_LONG  = 6;
  localparam int EXP_SHORT = 0;
`else
  localparam int W       = 100;
  localparam int LAT     = 3;
  localparam int PW      = 1;
  localparam int P_SHORT = 1;
  localparam int P_LONG  = 1;
  localparam int EXP_SHORT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  pulse_in;
  logic [7:0]  thr_hi, thr_lo;
  logic [15:0] count_out;
  logic        done, tick, led, buzzer;
  logic [1:0]  alarm;

  logic [3:0]  thr4 = 4'hF;
  logic [7:0]  count_out4;
  logic        done4, tick4, led4, buzzer4;
  logic [1:0]  alarm4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rpm_window_monitor #(.N_CH(2), .CNT_W(8), .WINDOW_CYCLES(W), .BUZZ_HALF(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pulse_in(pulse_in), .thr_hi(thr_hi), .thr_lo(thr_lo),
    .count_out(count_out), .done(done), .tick(tick), .alarm(alarm), .led(led), .buzzer(buzzer));

  rpm_window_monitor #(.N_CH(2), .CNT_W(4), .WINDOW_CYCLES(W), .BUZZ_HALF(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .pulse_in(pulse_in), .thr_hi(thr4), .thr_lo(thr4),
    .count_out(count_out4), .done(done4), .tick(tick4), .alarm(alarm4), .led(led4), .buzzer(buzzer4));

  typedef struct {
    int         n0;
    int         n1;
    logic [7:0] hi;
    logic [7:0] lo;
    logic [7:0] c0;
    logic [7:0] c1;
    logic [1:0] al;
    logic       led;
  } vec_t;

  vec_t vecs[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_pulses(input int n0, input int n1);
    int m;
    m = (n0 > n1) ? n0 : n1;
    for (int i = 0; i < m; i++) begin
      pulse_in = {(i < n1), (i < n0)};
      repeat (PW) step();
      pulse_in = '0;
      repeat (PW) step();
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3 * W; i++) begin
      step();
      if (done === 1'b1) break;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_count"},  32'(count_out), 32'd0);
    chk({tag, "_done"},   32'(done),      32'd0);
    chk({tag, "_tick"},   32'(tick),      32'd0);
    chk({tag, "_alarm"},  32'(alarm),     32'd0);
    chk({tag, "_led"},    32'(led),       32'd0);
    chk({tag, "_buzzer"}, 32'(buzzer),    32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t cv;
    logic prev_led;
    logic seen_done, seen_tick;
    int   c4;

    //         n0  n1  hi     lo     c0     c1     al     led
    vecs[0]  = '{1,  0, 8'd3,  8'd2,  8'd1,  8'd0,  2'b00, 1'b0};
    vecs[1]  = '{3,  0, 8'd3,  8'd2,  8'd3,  8'd0,  2'b01, 1'b1};
    vecs[2]  = '{2,  0, 8'd3,  8'd2,  8'd2,  8'd0,  2'b01, 1'b1};
    vecs[3]  = '{1,  0, 8'd3,  8'd2,  8'd1,  8'd0,  2'b00, 1'b0};
    vecs[4]  = '{0,  5, 8'd3,  8'd2,  8'd0,  8'd5,  2'b10, 1'b1};
    vecs[5]  = '{4,  2, 8'd3,  8'd2,  8'd4,  8'd2,  2'b11, 1'b1};
    vecs[6]  = '{0,  0, 8'd3,  8'd2,  8'd0,  8'd0,  2'b00, 1'b0};
    vecs[7]  = '{0,  0, 8'd0,  8'd2,  8'd0,  8'd0,  2'b11, 1'b1};
    vecs[8]  = '{4,  5, 8'd5,  8'd9,  8'd4,  8'd5,  2'b10, 1'b1};
    vecs[9]  = '{20, 0, 8'd200, 8'd100, 8'd20, 8'd0, 2'b00, 1'b0};
    vecs[10] = '{2,  3, 8'd3,  8'd1,  8'd2,  8'd3,  2'b10, 1'b1};

    rst_n = 1'b0; en = 1'b0; pulse_in = '0; thr_hi = 8'd3; thr_lo = 8'd2;
    repeat (3) step();
    chk_reset_outputs("reset");

    rst_n = 1'b1; en = 1'b1;
    step();
    chk("tick_first_window", 32'(tick), 32'd1);

    prev_led = 1'b0;
    for (int v = 0; v < 11; v++) begin
      cv = vecs[v];
      thr_hi = cv.hi;
      thr_lo = cv.lo;
      drive_pulses(cv.n0, cv.n1);
      wait_done();
      c4 = (cv.n0 > 15) ? 15 : cv.n0;
      chk($sformatf("v%0d_cnt0", v),  32'(count_out[7:0]),  32'(cv.c0));
      chk($sformatf("v%0d_cnt1", v),  32'(count_out[15:8]), 32'(cv.c1));
      chk($sformatf("v%0d_alarm", v), 32'(alarm),           32'(cv.al));
      chk($sformatf("v%0d_led", v),   32'(led),             32'(cv.led));
      chk($sformatf("v%0d_tick", v),  32'(tick),            32'd1);
      chk($sformatf("v%0d_sat4", v),  32'(count_out4[3:0]), 32'(c4));
      if (!cv.led) begin
        chk($sformatf("v%0d_buzz_off", v), 32'(buzzer), 32'd0);
      end else if (!prev_led) begin
        chk($sformatf("v%0d_buzz_c0", v), 32'(buzzer), 32'd1);
        for (int c = 1; c < 12; c++) begin
          step();
          chk($sformatf("v%0d_buzz_c%0d", v, c), 32'(buzzer), 32'(((c / 4) % 2) == 0));
        end
      end
      prev_led = cv.led;
    end

    // Enable dropped mid-window: partial window discarded, outputs hold.
    drive_pulses(2, 2);
    repeat (46) step();
    en = 1'b0;
    seen_done = 1'b0;
    seen_tick = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      step();
      if (done === 1'b1) seen_done = 1'b1;
      if (tick === 1'b1) seen_tick = 1'b1;
    end
    chk("en0_no_done",    32'(seen_done), 32'd0);
    chk("en0_no_tick",    32'(seen_tick), 32'd0);
    chk("en0_count_hold", 32'(count_out), 32'h0302);
    chk("en0_alarm_hold", 32'(alarm),     32'h2);
    en = 1'b1;
    step();
    chk("en1_tick", 32'(tick), 32'd1);

    // Edge on the terminal cycle closes with this window; edge on the tick cycle goes to the next.
    for (int c = 0; c < W; c++) begin
      pulse_in[0] = (c >= W - 1 - LAT) && (c < W - 1 - LAT + PW);
      pulse_in[1] = (c >= W - LAT) && (c < W - LAT + PW);
      step();
    end
    pulse_in = '0;
    chk("term_done", 32'(done), 32'd1);
    chk("term_cnt0", 32'(count_out[7:0]),  32'd1);
    chk("term_cnt1", 32'(count_out[15:8]), 32'd0);
    repeat (W) step();
    chk("next_done", 32'(done), 32'd1);
    chk("next_cnt0", 32'(count_out[7:0]),  32'd0);
    chk("next_cnt1", 32'(count_out[15:8]), 32'd1);

    // Reset mid-window while the alarm and buzzer are active.
    thr_hi = 8'd3; thr_lo = 8'd2;
    drive_pulses(3, 0);
    wait_done();
    chk("prerst_led",   32'(led),   32'd1);
    chk("prerst_alarm", 32'(alarm), 32'd1);
    repeat (20) step();
    rst_n = 1'b0;
    step();
    chk_reset_outputs("midrst");
    rst_n = 1'b1;
    step();
    chk("postrst_tick", 32'(tick), 32'd1);

    // Short pulse on ch0, long pulse on ch1.
    repeat (5) step();
    pulse_in[0] = 1'b1;
    repeat (P_SHORT) step();
    pulse_in[0] = 1'b0;
    repeat (10) step();
    pulse_in[1] = 1'b1;
    repeat (P_LONG) step();
    pulse_in = '0;
    wait_done();
    chk("short_cnt0", 32'(count_out[7:0]),  32'(EXP_SHORT));
    chk("long_cnt1",  32'(count_out[15:8]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
